relu_layer_seq: RTL and testbench

Sequencer that streams one layer's activation vector through the shared combinational leaky-ReLU unit. On start it reads LEN words from the source activation buffer and presents each word to the activation unit. It then writes each result, or the raw word in bypass mode, to the destination buffer. It sits between the MAC-array output buffer and the next layer's input buffer and is the only driver of the activation unit's input.

---
 rtl/relu_layer_seq.sv | 142 ++++++++++++++
 tb/tb_relu_layer_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/relu_layer_seq.sv
// Streams LEN words from the source buffer through the leaky-ReLU unit into the destination buffer.
// Read-to-write latency 2 cycles; a one-entry skid register absorbs the in-flight read under wr_ready backpressure.
module relu_layer_seq #(
  parameter int BIT_WIDTH  = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  len,
  input  logic [ADDR_WIDTH-1:0] src_base,
  input  logic [ADDR_WIDTH-1:0] dst_base,
  input  logic                  bypass,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [BIT_WIDTH-1:0]  rd_data,
  output logic [BIT_WIDTH-1:0]  act_x,
  input  logic [BIT_WIDTH-1:0]  act_y,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [BIT_WIDTH-1:0]  wr_data,
  input  logic                  wr_ready
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e                state_q, state_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
  logic [LEN_WIDTH-1:0]  wr_cnt_q, wr_cnt_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic                  byp_q, byp_d;
  logic                  infl_q, infl_d;
  logic                  wv_q, wv_d;
  logic [BIT_WIDTH-1:0]  cap_q, cap_d;
  logic                  skid_vld_q, skid_vld_d;
  logic [BIT_WIDTH-1:0]  skid_q, skid_d;
  logic                  wr_fire;
  logic                  w_free;

  assign wr_fire = wv_q && wr_ready;
  assign w_free  = !wv_q || wr_ready;

  // A read is only issued when both the skid slot and the write stage can absorb it.
  assign rd_en   = (state_q == RUN) && (rd_cnt_q < len_q) && !skid_vld_q && w_free;
  assign rd_addr = src_q + rd_cnt_q[ADDR_WIDTH-1:0];
  assign act_x   = cap_q;
  assign wr_en   = wv_q;
  assign wr_addr = dst_q + wr_cnt_q[ADDR_WIDTH-1:0];
  assign wr_data = wv_q ? (byp_q ? cap_q : act_y) : '0;
  assign busy    = (state_q == RUN) || (state_q == DRAIN);
  assign done    = (state_q == DONE);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    src_d      = src_q;
    dst_d      = dst_q;
    byp_d      = byp_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    infl_d     = rd_en;
    wv_d       = wv_q;
    cap_d      = cap_q;
    skid_vld_d = skid_vld_q;
    skid_d     = skid_q;

    if (rd_en)   rd_cnt_d = rd_cnt_q + 1'b1;
    if (wr_fire) wr_cnt_d = wr_cnt_q + 1'b1;

    // Skid entry is older than the in-flight word, so it enters the write stage first.
    if (w_free) begin
      if (skid_vld_q) begin
        wv_d       = 1'b1;
        cap_d      = skid_q;
        skid_vld_d = infl_q;
        if (infl_q) skid_d = rd_data;
      end else if (infl_q) begin
        wv_d  = 1'b1;
        cap_d = rd_data;
      end else begin
        wv_d = 1'b0;
      end
    end else if (infl_q) begin
      skid_vld_d = 1'b1;
      skid_d     = rd_data;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          len_d    = len;
          src_d    = src_base;
          dst_d    = dst_base;
          byp_d    = bypass;
          rd_cnt_d = '0;
          wr_cnt_d = '0;
          state_d  = (len != '0) ? RUN : DONE;
        end
      end
      RUN:     if (rd_cnt_q == len_q) state_d = DRAIN;
      DRAIN:   if (wr_cnt_d == len_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      len_q      <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      byp_q      <= 1'b0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      infl_q     <= 1'b0;
      wv_q       <= 1'b0;
      cap_q      <= '0;
      skid_vld_q <= 1'b0;
      skid_q     <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      byp_q      <= byp_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      infl_q     <= infl_d;
      wv_q       <= wv_d;
      cap_q      <= cap_d;
      skid_vld_q <= skid_vld_d;
      skid_q     <= skid_d;
    end
  end

endmodule

// File: tb/tb_relu_layer_seq.sv
// Scoreboarded bench for relu_layer_seq: source memory model, leaky-ReLU model, randomized transfers.
module tb_relu_layer_seq;
  localparam int BW = 32;
  localparam int AW = 10;
  localparam int LW = 11;

  logic          clk, rst_n, start, bypass, busy, done, rd_en, wr_en, wr_ready;
  logic [LW-1:0] len;
  logic [AW-1:0] src_base, dst_base, rd_addr, wr_addr;
  logic [BW-1:0] rd_data, act_x, act_y, wr_data;
  logic [BW-1:0] mem [0:(1<<AW)-1];

  int checks = 0;
  int failures = 0;
  int wr_seen = 0;
  bit mon_en = 0;
  bit stall_prev = 0;
  logic [AW-1:0] prev_addr;
  logic [BW-1:0] prev_data;
  logic [AW-1:0]    exp_rd_q[$];
  logic [AW+BW-1:0] exp_wr_q[$];

  relu_layer_seq #(.BIT_WIDTH(BW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .src_base(src_base),
    .dst_base(dst_base), .bypass(bypass), .busy(busy), .done(done), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .act_x(act_x), .act_y(act_y),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready)
  );

  function automatic logic [BW-1:0] leaky(input logic [BW-1:0] x);
    logic signed [BW-1:0] s;
    s = x;
    return x[BW-1] ? BW'(s >>> 3) : x;
  endfunction

  assign act_y = leaky(act_x);

  initial clk = 0;
  always #5 clk = ~clk;

  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (mon_en && rst_n) begin
      if (wr_en && !wr_ready) chk("rd_during_stall", rd_en, 0);
      if (stall_prev) begin
        chk("hold_wr_en", wr_en, 1);
        chk("hold_wr_addr", wr_addr, prev_addr);
        chk("hold_wr_data", wr_data, prev_data);
      end
      if (rd_en) begin
        if (exp_rd_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL rd_unexpected: read at %h, no read expected", rd_addr);
        end else chk("rd_addr", rd_addr, exp_rd_q.pop_front());
      end
      if (wr_en && wr_ready) begin
        wr_seen++;
        if (exp_wr_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL wr_unexpected: write %h=%h, no write expected", wr_addr, wr_data);
        end else chk("wr_addr_data", {wr_addr, wr_data}, exp_wr_q.pop_front());
      end
      stall_prev = wr_en && !wr_ready;
      prev_addr  = wr_addr;
      prev_data  = wr_data;
    end
  end

  task automatic push_expect(input int n, input logic [AW-1:0] sb, input logic [AW-1:0] db,
                             input logic byp);
    logic [AW-1:0] a;
    logic [BW-1:0] d;
    for (int i = 0; i < n; i++) begin
      a = sb + AW'(i);
      d = mem[a];
      exp_rd_q.push_back(a);
      exp_wr_q.push_back({AW'(db + AW'(i)), byp ? d : leaky(d)});
    end
  endtask

  task automatic pulse_start(input int n, input logic [AW-1:0] sb, input logic [AW-1:0] db,
                             input logic byp);
    start = 1; len = LW'(n); src_base = sb; dst_base = db; bypass = byp;
    @(posedge clk); #1;
    start = 0;
    len = LW'($urandom); src_base = AW'($urandom); dst_base = AW'($urandom); bypass = $urandom;
  endtask

  // rmode: 0 ready always high, 1 random ready, 2 three-cycle stall from the 2nd write
  task automatic run_xfer(input int n, input logic [AW-1:0] sb, input logic [AW-1:0] db,
                          input logic byp, input int rmode, input bit coinc);
    int k;
    int stall_left;
    bit stalled;
    k = 1; stall_left = 0; stalled = 0;
    wr_seen = 0;
    push_expect(n, sb, db, byp);
    pulse_start(n, sb, db, byp);
    chk("busy_after_start", busy, n != 0);
    forever begin
      if (rmode == 1) wr_ready = ($urandom_range(0, 9) < 7);
      else if (rmode == 2) begin
        if (wr_seen == 1 && !stalled) begin stall_left = 3; stalled = 1; end
        wr_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
      end else wr_ready = 1;
      start = (rmode == 1 && k == 3);
      if (done) break;
      if (k >= 3000) begin
        checks++; failures++;
        $display("FAIL done_timeout: no done after %0d cycles, len %0d", k, n);
        break;
      end
      @(posedge clk); #1; k++;
    end
    start = 0;
    if (rmode == 0) chk("done_cycles", k, (n == 0) ? 1 : n + 3);
    chk("busy_at_done", busy, 0);
    if (coinc) begin
      start = 1; len = 3; src_base = 0; dst_base = 0; bypass = 0;
      @(posedge clk); #1; start = 0;
      for (int i = 0; i < 3; i++) begin
        chk("coinc_start_ignored", busy, 0);
        @(posedge clk); #1;
      end
    end
    wr_ready = 1;
    repeat (2) begin @(posedge clk); #1; end
    chk("wr_count", wr_seen, n);
    chk("wr_queue_empty", exp_wr_q.size(), 0);
    chk("rd_queue_empty", exp_rd_q.size(), 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
    chk({tag, "_wr_data"}, wr_data, 0);
    chk({tag, "_act_x"}, act_x, 0);
  endtask

  initial begin
    logic [BW-1:0] vec [4];
    int k;
    vec[0] = 32'h0001_0000; vec[1] = 32'hFFFF_0000; vec[2] = 32'h0; vec[3] = 32'h8000_0008;
    rst_n = 0; start = 0; len = 0; src_base = 0; dst_base = 0; bypass = 0; wr_ready = 1;
    for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    for (int i = 0; i < 4; i++) mem[16 + i] = vec[i];
    #1;
    chk_outputs_zero("reset");
    repeat (2) @(posedge clk);
    #1; rst_n = 1; mon_en = 1;

    run_xfer(4, 10'h010, 10'h100, 0, 0, 1);
    run_xfer(4, 10'h010, 10'h100, 1, 0, 0);
    run_xfer(6, 10'h200, 10'h280, 0, 2, 0);
    run_xfer(0, 10'h050, 10'h060, 0, 0, 0);
    run_xfer(3, 10'h3FE, 10'h3FF, 0, 0, 0);

    // Reset mid-transfer after two of five writes.
    wr_seen = 0;
    push_expect(5, 10'h120, 10'h300, 0);
    pulse_start(5, 10'h120, 10'h300, 0);
    k = 0;
    while (wr_seen < 2 && k < 100) begin @(posedge clk); #1; k++; end
    chk("reset_test_reached_2_writes", wr_seen, 2);
    #1; rst_n = 0; mon_en = 0;
    #1;
    chk_outputs_zero("midrun_reset");
    exp_rd_q.delete(); exp_wr_q.delete(); stall_prev = 0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1; mon_en = 1;
    @(posedge clk); #1;
    chk("idle_after_reset_busy", busy, 0);
    chk("idle_after_reset_rd_en", rd_en, 0);
    run_xfer(5, 10'h120, 10'h300, 0, 0, 0);

    for (int r = 0; r < 6; r++)
      run_xfer($urandom_range(1, 40), AW'($urandom), AW'($urandom), 1'($urandom), 1, 0);
    run_xfer(20, 10'h3F0, 10'h3F8, 0, 1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
